// File: rtl/adc_scan_pkg.sv
// Shared state encoding, channel-field width and ADC code to millivolt conversion for the scan sampler.
package adc_scan_pkg;

  localparam int ADC_CH_W = 5;
  localparam int MAX_CH   = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACCUM} scan_state_t;

  // Round-to-nearest scaling of a full-scale code range onto fs millivolts.
  function automatic logic [31:0] code_to_mv(input logic [31:0] code, input int adc_w, input int fs);
    logic [63:0] den;
    logic [63:0] num;
    den = (64'd1 << adc_w) - 64'd1;
    num = {32'd0, code} * 64'(fs) + (den >> 1);
    return 32'(num / den);
  endfunction

endpackage

// File: rtl/adc_hyst_cmp.sv
// Hysteresis flag: sets at or above thr_hi, clears below thr_lo, otherwise holds; evaluated only when upd is high.
// Registered: the flag reflects value one cycle after upd; no backpressure.
module adc_hyst_cmp #(
  parameter int MV_W = 13
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            upd,
  input  logic [MV_W-1:0] value,
  input  logic [MV_W-1:0] thr_hi,
  input  logic [MV_W-1:0] thr_lo,
  output logic            flag
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag <= 1'b0;
    end else if (upd) begin
      if (value >= thr_hi)
        flag <= 1'b1;
      else if (value < thr_lo)
        flag <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_scan_sampler.sv
// Round-robin ADC scanner: issues one command per channel, converts to mV, averages, publishes; optional watchdog via ADC_SCAN_TIMEOUT_EN.
// Response to mv_valid is 2 cycles; cmd_valid/cmd_channel hold until cmd_ready, WAIT blocks until the matching response.
module adc_scan_sampler
  import adc_scan_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CH_BASE       = 1,
  parameter int ADC_W         = 12,
  parameter int FULL_SCALE_MV = 5000,
  parameter int MV_W          = 13,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   cmd_valid,
  output logic [ADC_CH_W-1:0]    cmd_channel,
  output logic                   cmd_sop,
  output logic                   cmd_eop,
  input  logic                   cmd_ready,
  input  logic                   rsp_valid,
  input  logic [ADC_CH_W-1:0]    rsp_channel,
  input  logic [ADC_W-1:0]       rsp_data,
  input  logic [MV_W-1:0]        thr_hi,
  input  logic [MV_W-1:0]        thr_lo,
  output logic [NUM_CH*MV_W-1:0] mv_data,
  output logic                   mv_valid,
  output logic [2:0]             mv_index,
  output logic [NUM_CH-1:0]      trig,
  output logic                   err_mismatch,
  output logic                   err_timeout
);

  localparam int               ACC_W    = MV_W + AVG_LOG2;
  localparam int               CNT_W    = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_CH - 1);

  scan_state_t         state, state_nxt;
  logic [2:0]          idx;
  logic [MV_W-1:0]     mv_conv;
  logic [MV_W-1:0]     mv_reg;
  logic [ACC_W-1:0]    acc [MAX_CH];
  logic [CNT_W-1:0]    cnt [MAX_CH];
  logic [ADC_CH_W-1:0] exp_ch;
  logic                rsp_match;
  logic                timed_out;
  logic                publish;
  logic [ACC_W-1:0]    acc_sum;
  logic [MV_W-1:0]     avg;

  assign exp_ch    = ADC_CH_W'(CH_BASE) + ADC_CH_W'(idx);
  assign rsp_match = (state == WAIT) && rsp_valid && (rsp_channel == exp_ch);
  assign mv_conv   = MV_W'(code_to_mv(32'(rsp_data), ADC_W, FULL_SCALE_MV));
  assign acc_sum   = acc[idx] + ACC_W'(mv_reg);
  assign avg       = acc_sum[ACC_W-1:AVG_LOG2];
  assign publish   = (state == ACCUM) && (cnt[idx] == CNT_LAST);
  assign cmd_sop   = 1'b1;
  assign cmd_eop   = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_valid   = 1'b0;
    cmd_channel = '0;
    unique case (state)
      IDLE:  if (enable) state_nxt = ISSUE;
      ISSUE: begin
        cmd_valid   = 1'b1;
        cmd_channel = exp_ch;
        if (cmd_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (rsp_match)      state_nxt = ACCUM;
        else if (timed_out) state_nxt = ISSUE;
      end
      ACCUM:   state_nxt = enable ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Any response outside a matching WAIT is unexpected and only flags the error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= 3'd0;
      mv_reg       <= '0;
      mv_data      <= '0;
      mv_valid     <= 1'b0;
      mv_index     <= 3'd0;
      err_mismatch <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      mv_valid <= 1'b0;
      if (rsp_valid && !rsp_match) err_mismatch <= 1'b1;
      if (rsp_match) mv_reg <= mv_conv;
      if (state == ACCUM) begin
        if (publish) begin
          acc[idx] <= '0;
          cnt[idx] <= '0;
          mv_valid <= 1'b1;
          mv_index <= idx;
          for (int i = 0; i < NUM_CH; i++)
            if (idx == 3'(i)) mv_data[i*MV_W +: MV_W] <= avg;
        end else begin
          acc[idx] <= acc_sum;
          cnt[idx] <= cnt[idx] + 1'b1;
        end
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_hyst
    adc_hyst_cmp #(.MV_W(MV_W)) u_hyst (
      .clk    (clk),
      .reset  (reset),
      .upd    (publish && (idx == 3'(i))),
      .value  (avg),
      .thr_hi (thr_hi),
      .thr_lo (thr_lo),
      .flag   (trig[i])
    );
  end

`ifdef ADC_SCAN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  assign timed_out = (state == WAIT) && !rsp_match && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Expiry drops the sample and retries the same channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state != WAIT)   wd_cnt <= '0;
      else if (!rsp_match) wd_cnt <= wd_cnt + 1'b1;
      if (timed_out) err_timeout <= 1'b1;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign err_timeout = 1'b0 & (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_adc_scan_sampler.sv
// Randomized bench for adc_scan_sampler with a per-channel averaging/hysteresis model and per-cycle output compare.
`timescale 1ns/1ps
module tb_adc_scan_sampler;

  localparam int NUM_CH = 4, CH_BASE = 1, ADC_W = 12, FS = 5000, MV_W = 13, AVG_LOG2 = 2, TMO = 16;
  localparam int NAVG = 1 << AVG_LOG2;

  logic                   clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic                   cmd_valid, cmd_sop, cmd_eop, cmd_ready = 1'b0;
  logic [4:0]             cmd_channel, rsp_channel = 5'd0;
  logic                   rsp_valid = 1'b0;
  logic [ADC_W-1:0]       rsp_data = '0;
  logic [MV_W-1:0]        thr_hi = 13'd3000, thr_lo = 13'd2000;
  logic [NUM_CH*MV_W-1:0] mv_data;
  logic                   mv_valid, err_mismatch, err_timeout;
  logic [2:0]             mv_index;
  logic [NUM_CH-1:0]      trig;

  adc_scan_sampler #(.NUM_CH(NUM_CH), .CH_BASE(CH_BASE), .ADC_W(ADC_W), .FULL_SCALE_MV(FS),
                     .MV_W(MV_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_sop(cmd_sop), .cmd_eop(cmd_eop),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .mv_data(mv_data), .mv_valid(mv_valid), .mv_index(mv_index),
    .trig(trig), .err_mismatch(err_mismatch), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: per-channel running sums, published values, flags, next expected channel index.
  int  macc[NUM_CH], mcnt[NUM_CH], mpub[NUM_CH];
  bit  mtrig[NUM_CH];
  int  eidx = 0;
  bit  pend = 0;
  int  pend_cyc = 0, pend_idx = 0, pend_val = 0;
  bit  pend_trg = 0;
  int  merr_from = 1 << 30;
  bit  run = 0;

  function automatic int model_mv(input int code);
    return (code * FS + ((1 << ADC_W) - 1) / 2) / ((1 << ADC_W) - 1);
  endfunction

  function automatic logic [NUM_CH*MV_W-1:0] pack_pub();
    logic [NUM_CH*MV_W-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i*MV_W +: MV_W] = MV_W'(mpub[i]);
    return r;
  endfunction

  task automatic model_sample(input int code);
    macc[eidx] += model_mv(code);
    mcnt[eidx]++;
    if (mcnt[eidx] == NAVG) begin
      pend     = 1;
      pend_cyc = cyc + 2;
      pend_idx = eidx;
      pend_val = macc[eidx] / NAVG;
      if (pend_val >= int'(thr_hi))     pend_trg = 1;
      else if (pend_val < int'(thr_lo)) pend_trg = 0;
      else                              pend_trg = mtrig[eidx];
      macc[eidx] = 0;
      mcnt[eidx] = 0;
    end
    eidx = (eidx + 1) % NUM_CH;
  endtask

  task automatic note_err();
    if (merr_from > cyc + 1) merr_from = cyc + 1;
  endtask

  always @(negedge clk) begin : cmp
    logic [NUM_CH-1:0] et;
    if (run) begin
      if (pend && cyc == pend_cyc) begin
        mpub[pend_idx]  = pend_val;
        mtrig[pend_idx] = pend_trg;
        pend = 0;
        chk("mv_valid_pulse", 64'(mv_valid), 64'd1);
        chk("mv_index", 64'(mv_index), 64'(pend_idx));
      end else begin
        chk("mv_valid_quiet", 64'(mv_valid), 64'd0);
      end
      for (int i = 0; i < NUM_CH; i++) et[i] = mtrig[i];
      chk("mv_data", 64'(mv_data), 64'(pack_pub()));
      chk("trig", 64'(trig), 64'(et));
      chk("err_mismatch", 64'(err_mismatch), 64'(cyc >= merr_from));
`ifndef ADC_SCAN_TIMEOUT_EN
      chk("err_timeout", 64'(err_timeout), 64'd0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd();
    int n = 0;
    while (!cmd_valid && n < 40) begin
      step();
      n++;
    end
    chk("cmd_valid_wait", 64'(cmd_valid), 64'd1);
  endtask

  // stray: 0 none, 1 bogus response while the command is pending, 2 wrong channel while waiting.
  task automatic xact(input int code, input int rdy_dly, input int rsp_dly, input int stray, input bit drop);
    int ch;
    ch = CH_BASE + eidx;
    wait_cmd();
    for (int i = 0; i < rdy_dly; i++) begin
      chk("cmd_hold_valid", 64'(cmd_valid), 64'd1);
      chk("cmd_hold_channel", 64'(cmd_channel), 64'(ch));
      if (stray == 1 && i == 0) begin
        rsp_valid   = 1'b1;
        rsp_channel = 5'($urandom);
        rsp_data    = ADC_W'($urandom);
        note_err();
      end
      step();
      rsp_valid = 1'b0;
    end
    chk("cmd_channel", 64'(cmd_channel), 64'(ch));
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    if (drop) enable = 1'b0;
    chk("cmd_drop_after_accept", 64'(cmd_valid), 64'd0);
    if (stray == 2) begin
      rsp_valid   = 1'b1;
      rsp_channel = 5'((ch + 1 + int'($urandom_range(0, 29))) % 32);
      note_err();
      step();
      rsp_valid = 1'b0;
      chk("still_wait", 64'(cmd_valid), 64'd0);
    end
    repeat (rsp_dly) step();
    rsp_valid   = 1'b1;
    rsp_channel = 5'(ch);
    rsp_data    = ADC_W'(code);
    model_sample(code);
    step();
    rsp_valid = 1'b0;
  endtask

  task automatic check_pub(input int i, input int mv, input int tr, input string nm);
    step();
    chk({nm, "_valid"}, 64'(mv_valid), 64'd1);
    chk({nm, "_mv"}, 64'(mv_data[i*MV_W +: MV_W]), 64'(mv));
    chk({nm, "_trig"}, 64'(trig[i]), 64'(tr));
  endtask

  function automatic int t3_code(input int r, input int s);
    case (r)
      0:       return 0;
      2:       return 2539;
      4:       return 1556;
      default: return (s % 2 == 0) ? 2047 : 2048;
    endcase
  endfunction

  int t3_mv[5] = '{0, 2500, 3100, 2500, 1900};
  int t3_tr[5] = '{0, 0, 1, 1, 0};

  initial begin
    int code, rdy, st;
    bit dr;
    repeat (3) step();
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd_channel", 64'(cmd_channel), 64'd0);
    chk("rst_mv_data", 64'(mv_data), 64'd0);
    chk("rst_trig", 64'(trig), 64'd0);
    chk("rst_err", 64'({err_mismatch, err_timeout}), 64'd0);
    reset = 1'b0;
    run   = 1;
    step();
    enable = 1'b1;
    step();
    step();
    chk("first_channel", 64'(cmd_channel), 64'd1);

    // Full-scale echo on every channel.
    for (int j = 0; j < 4 * NUM_CH; j++) xact(4095, 0, 0, 0, 0);
    step();
    for (int i = 0; i < NUM_CH; i++) begin
      chk("t1_mv", 64'(mv_data[i*MV_W +: MV_W]), 64'd5000);
      chk("t1_trig", 64'(trig[i]), 64'd1);
    end

    // Channel index 0 averages 0,4095,0,4095.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < NUM_CH; c++) begin
        xact((c == 0) ? ((r % 2 == 0) ? 0 : 4095) : int'($urandom_range(0, 4095)), 0, 0, 0, 0);
        if (c == 0 && r == 2) begin
          step();
          chk("t2_no_pub", 64'(mv_valid), 64'd0);
        end
        if (c == 0 && r == 3) check_pub(0, 2500, 1, "t2");
      end

    // Hysteresis on channel index 1.
    for (int r = 0; r < 5; r++)
      for (int s = 0; s < NAVG; s++)
        for (int c = 0; c < NUM_CH; c++) begin
          xact((c == 1) ? t3_code(r, s) : int'($urandom_range(0, 4095)), 0, 0, 0, 0);
          if (c == 1 && s == NAVG - 1) check_pub(1, t3_mv[r], t3_tr[r], "t3");
        end

    // Wrong-channel response dropped, then the right one completes.
    xact(1234, 0, 2, 2, 0);
    chk("t5_err", 64'(err_mismatch), 64'd1);
    // Long backpressure with a stray response while the command is pending.
    xact(777, 10, 0, 1, 0);

    for (int j = 0; j < 40; j++) begin
      code = int'($urandom_range(0, 4095));
      rdy  = int'($urandom_range(0, 3));
      st   = int'($urandom_range(0, 7));
      if (st == 1 && rdy == 0) st = 0;
      if (st > 2) st = 0;
      dr = ($urandom_range(0, 5) == 0);
      xact(code, rdy, int'($urandom_range(0, 4)), st, dr);
      if (dr) begin
        repeat (3) begin
          step();
          chk("idle_hold", 64'(cmd_valid), 64'd0);
        end
        enable = 1'b1;
      end
    end

`ifdef ADC_SCAN_TIMEOUT_EN
    begin
      int ch;
      wait_cmd();
      ch = CH_BASE + eidx;
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      repeat (TMO) begin
        chk("to_pending", 64'(err_timeout), 64'd0);
        step();
      end
      chk("to_flag", 64'(err_timeout), 64'd1);
      chk("to_reissue", 64'(cmd_valid), 64'd1);
      chk("to_same_ch", 64'(cmd_channel), 64'(ch));
    end
`endif

    // Reset while waiting for a response.
    run = 0;
    wait_cmd();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rstw_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rstw_cmd_channel", 64'(cmd_channel), 64'd0);
    chk("rstw_mv_data", 64'(mv_data), 64'd0);
    chk("rstw_mv_valid", 64'({mv_valid, mv_index}), 64'd0);
    chk("rstw_trig", 64'(trig), 64'd0);
    chk("rstw_err", 64'({err_mismatch, err_timeout}), 64'd0);
    step();
    chk("rstw_hold", 64'(cmd_valid), 64'd0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "global timeout");
  end

endmodule
